memmu_cr_address_gen: RTL and testbench

//  Parametrised successor of the MemMU cartesian-representation address unit.
//  - Turns each SIU point into a MemMU word address through a 2-stage valid/ready pipeline.
//  - Per-channel base/size regions, with two modes: point-ID passthrough or cartesian (y*rowWidth + x).
//  - Out-of-region points are dropped and counted.
//  - Sits between the SIU point stream and the MemMU write port.

---
 rtl/memmu_cr_address_gen_if.sv | 44 ++++
 rtl/memmu_cr_address_gen.sv | 91 +++++++++
 tb/tb_memmu_cr_address_gen.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memmu_cr_address_gen_if.sv
// memmu_cr_address_gen_if: SIU point stream, region config and MemMU address port.
interface memmu_cr_address_gen_if #(
    parameter int ADDR_W = 19,
    parameter int ID_W   = 19,
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int NUM_CH = 4,
    parameter int CH_W   = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
    parameter int CNT_W  = 16
);
    logic              i_SIU_valid;
    logic              o_SIU_ready;
    logic [CH_W-1:0]   i_SIU_channel;
    logic [ID_W-1:0]   i_SIU_pointID;
    logic [X_W-1:0]    i_SIU_x;
    logic [Y_W-1:0]    i_SIU_y;
    logic              i_cfg_mode;
    logic [X_W:0]      i_cfg_rowWidth;
    logic              i_cfg_we;
    logic [CH_W-1:0]   i_cfg_ch;
    logic [ADDR_W-1:0] i_cfg_base;
    logic [ADDR_W:0]   i_cfg_size;
    logic              o_MemMU_CR_A_valid;
    logic              i_MemMU_ready;
    logic [ADDR_W-1:0] o_MemMU_CR_A_address;
    logic [CH_W-1:0]   o_MemMU_CR_A_channel;
    logic [CNT_W-1:0]  o_MemMU_CR_A_dropCount;

    modport master (
        output i_SIU_valid, i_SIU_channel, i_SIU_pointID, i_SIU_x, i_SIU_y,
        output i_cfg_mode, i_cfg_rowWidth, i_cfg_we, i_cfg_ch, i_cfg_base, i_cfg_size,
        output i_MemMU_ready,
        input  o_SIU_ready, o_MemMU_CR_A_valid, o_MemMU_CR_A_address,
        input  o_MemMU_CR_A_channel, o_MemMU_CR_A_dropCount
    );

    modport slave (
        input  i_SIU_valid, i_SIU_channel, i_SIU_pointID, i_SIU_x, i_SIU_y,
        input  i_cfg_mode, i_cfg_rowWidth, i_cfg_we, i_cfg_ch, i_cfg_base, i_cfg_size,
        input  i_MemMU_ready,
        output o_SIU_ready, o_MemMU_CR_A_valid, o_MemMU_CR_A_address,
        output o_MemMU_CR_A_channel, o_MemMU_CR_A_dropCount
    );
endinterface

// File: rtl/memmu_cr_address_gen.sv
// memmu_cr_address_gen: 2-stage SIU point -> MemMU word address translator with
// per-channel base/size regions; out-of-region points are dropped and counted.
module memmu_cr_address_gen #(
    parameter int ADDR_W = 19,
    parameter int ID_W   = 19,
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int NUM_CH = 4,
    parameter int CH_W   = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
    parameter int CNT_W  = 16
) (
    input logic i_SYSTEM_clk,
    input logic i_SYSTEM_rst,
    memmu_cr_address_gen_if.slave bus
);
    localparam int OFF_W  = ADDR_W + 1;
    localparam int PROD_W = X_W + Y_W + 2;
    localparam int SRC_W  = PROD_W > ID_W ? PROD_W : ID_W;
    // At least one bit above the offset so saturation detection always has a slice to test
    localparam int FULL_W = (SRC_W > OFF_W ? SRC_W : OFF_W) + 1;

    logic [ADDR_W-1:0] base [NUM_CH];
    logic [ADDR_W:0]   size [NUM_CH];
    logic              s1Valid;
    logic [OFF_W-1:0]  s1Offset;
    logic [CH_W-1:0]   s1Channel;
    logic              outValid;
    logic [ADDR_W-1:0] outAddress;
    logic [CH_W-1:0]   outChannel;
    logic [CNT_W-1:0]  dropCount;
    logic [FULL_W-1:0] fullOffset;
    logic [OFF_W-1:0]  newOffset;
    logic [CH_W-1:0]   chIdx;
    logic              chOk, drop, s1Advance, siuReady, cfgHit;

    assign fullOffset = bus.i_cfg_mode
        ? FULL_W'(bus.i_SIU_y) * FULL_W'(bus.i_cfg_rowWidth) + FULL_W'(bus.i_SIU_x)
        : FULL_W'(bus.i_SIU_pointID);
    assign newOffset = |fullOffset[FULL_W-1:OFF_W] ? '1 : fullOffset[OFF_W-1:0];

    assign chOk      = int'(s1Channel) < NUM_CH;
    assign chIdx     = chOk ? s1Channel : '0;
    assign drop      = !chOk || s1Offset >= size[chIdx];
    // A dropped point never waits on the output register
    assign s1Advance = s1Valid && (drop || !outValid || bus.i_MemMU_ready);
    assign siuReady  = !s1Valid || s1Advance;
    assign cfgHit    = bus.i_cfg_we && int'(bus.i_cfg_ch) < NUM_CH;

    assign bus.o_SIU_ready            = siuReady && !i_SYSTEM_rst;
    assign bus.o_MemMU_CR_A_valid     = outValid;
    assign bus.o_MemMU_CR_A_address   = outAddress;
    assign bus.o_MemMU_CR_A_channel   = outChannel;
    assign bus.o_MemMU_CR_A_dropCount = dropCount;

    always_ff @(posedge i_SYSTEM_clk or posedge i_SYSTEM_rst) begin
        if (i_SYSTEM_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                base[i] <= '0;
                size[i] <= {1'b1, {ADDR_W{1'b0}}};
            end
            s1Valid    <= 1'b0;
            s1Offset   <= '0;
            s1Channel  <= '0;
            outValid   <= 1'b0;
            outAddress <= '0;
            outChannel <= '0;
            dropCount  <= '0;
        end else begin
            if (cfgHit) begin
                base[bus.i_cfg_ch] <= bus.i_cfg_base;
                size[bus.i_cfg_ch] <= bus.i_cfg_size;
            end
            if (siuReady) begin
                s1Valid <= bus.i_SIU_valid;
                if (bus.i_SIU_valid) begin
                    s1Offset  <= newOffset;
                    s1Channel <= bus.i_SIU_channel;
                end
            end
            if (s1Advance && !drop) begin
                outValid   <= 1'b1;
                outAddress <= base[chIdx] + s1Offset[ADDR_W-1:0];
                outChannel <= s1Channel;
            end else if (bus.i_MemMU_ready) begin
                outValid <= 1'b0;
            end
            if (s1Advance && drop && !(&dropCount))
                dropCount <= dropCount + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_memmu_cr_address_gen.sv
// tb_memmu_cr_address_gen: directed vectors with a queue scoreboard and a decoupled
// output monitor; a second 3-channel instance covers out-of-range channel handling.
module tb_memmu_cr_address_gen;
    typedef struct packed {
        logic [18:0] addr;
        logic [1:0]  ch;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memmu_cr_address_gen_if bus ();
    memmu_cr_address_gen_if #(.NUM_CH(3), .CH_W(2)) bus3 ();

    memmu_cr_address_gen dut (.i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst), .bus(bus));
    memmu_cr_address_gen #(.NUM_CH(3), .CH_W(2)) dut3 (.i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst), .bus(bus3));

    exp_t q[$];
    exp_t q3[$];
    int total = 0;
    int bad = 0;
    int expDrop = 0;
    int readyMode = 0;
    logic prevStall = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = stalled
    initial begin
        logic [3:0] pat;
        int idx;
        pat = 4'b1001;
        idx = 0;
        bus.i_MemMU_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (readyMode == 1) begin
                bus.i_MemMU_ready = pat[idx % 4];
                idx++;
            end else begin
                bus.i_MemMU_ready = (readyMode == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prevStall <= 1'b0;
        end else begin
            if (prevStall)
                check("stall_hold_valid", 64'(bus.o_MemMU_CR_A_valid), 64'd1);
            if (bus.o_MemMU_CR_A_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out actual=%0h required=none", bus.o_MemMU_CR_A_address);
                end else begin
                    check("out_addr", 64'(bus.o_MemMU_CR_A_address), 64'(q[0].addr));
                    check("out_ch", 64'(bus.o_MemMU_CR_A_channel), 64'(q[0].ch));
                    if (bus.i_MemMU_ready)
                        void'(q.pop_front());
                end
            end
            prevStall <= bus.o_MemMU_CR_A_valid && !bus.i_MemMU_ready;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus3.o_MemMU_CR_A_valid) begin
            if (q3.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out3 actual=%0h required=none", bus3.o_MemMU_CR_A_address);
            end else begin
                check("out3_addr", 64'(bus3.o_MemMU_CR_A_address), 64'(q3[0].addr));
                check("out3_ch", 64'(bus3.o_MemMU_CR_A_channel), 64'(q3[0].ch));
                void'(q3.pop_front());
            end
        end
    end

    task automatic sendPoint(input logic [1:0] ch, input logic mode, input logic [18:0] id,
                             input logic [9:0] x, input logic [8:0] y,
                             input logic ok, input logic [18:0] ea);
        logic acc;
        acc = 1'b0;
        bus.i_SIU_valid   = 1'b1;
        bus.i_SIU_channel = ch;
        bus.i_cfg_mode    = mode;
        bus.i_SIU_pointID = id;
        bus.i_SIU_x       = x;
        bus.i_SIU_y       = y;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = bus.o_SIU_ready;
            if (acc) begin
                if (ok) q.push_back('{addr: ea, ch: ch});
                else expDrop++;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=not_ready required=accept");
        end
        bus.i_SIU_valid = 1'b0;
    endtask

    task automatic sendPoint3(input logic [1:0] ch, input logic [18:0] id,
                              input logic ok, input logic [18:0] ea);
        bus3.i_SIU_valid   = 1'b1;
        bus3.i_SIU_channel = ch;
        bus3.i_SIU_pointID = id;
        @(negedge clk);
        check("ready3", 64'(bus3.o_SIU_ready), 64'd1);
        if (ok) q3.push_back('{addr: ea, ch: ch});
        @(posedge clk);
        #1;
        bus3.i_SIU_valid = 1'b0;
    endtask

    task automatic cfgWrite(input logic [1:0] ch, input logic [18:0] b, input logic [19:0] s);
        bus.i_cfg_we   = 1'b1;
        bus.i_cfg_ch   = ch;
        bus.i_cfg_base = b;
        bus.i_cfg_size = s;
        @(posedge clk);
        #1;
        bus.i_cfg_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || q3.size() != 0 || bus.o_MemMU_CR_A_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_SIU_valid = 1'b0;  bus.i_SIU_channel = '0; bus.i_SIU_pointID = '0;
        bus.i_SIU_x = '0;        bus.i_SIU_y = '0;       bus.i_cfg_mode = 1'b0;
        bus.i_cfg_rowWidth = '0; bus.i_cfg_we = 1'b0;    bus.i_cfg_ch = '0;
        bus.i_cfg_base = '0;     bus.i_cfg_size = '0;
        bus3.i_SIU_valid = 1'b0; bus3.i_SIU_channel = '0; bus3.i_SIU_pointID = '0;
        bus3.i_SIU_x = '0;       bus3.i_SIU_y = '0;      bus3.i_cfg_mode = 1'b0;
        bus3.i_cfg_rowWidth = '0; bus3.i_cfg_we = 1'b0;  bus3.i_cfg_ch = '0;
        bus3.i_cfg_base = '0;    bus3.i_cfg_size = '0;   bus3.i_MemMU_ready = 1'b1;
        #2;
        check("rst_valid", 64'(bus.o_MemMU_CR_A_valid), 64'd0);
        check("rst_siu_ready", 64'(bus.o_SIU_ready), 64'd0);
        check("rst_addr", 64'(bus.o_MemMU_CR_A_address), 64'd0);
        check("rst_ch", 64'(bus.o_MemMU_CR_A_channel), 64'd0);
        check("rst_drop", 64'(bus.o_MemMU_CR_A_dropCount), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("siu_ready_after_rst", 64'(bus.o_SIU_ready), 64'd1);

        // Passthrough on default region, with 2-cycle latency
        sendPoint(2'd0, 1'b0, 19'h12345, '0, '0, 1'b1, 19'h12345);
        check("lat_not_yet", 64'(bus.o_MemMU_CR_A_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(bus.o_MemMU_CR_A_valid), 64'd1);
        drain();

        // Cartesian: 3*640+10 = 1930 on base 0x1000
        cfgWrite(2'd1, 19'h01000, 20'h10000);
        bus.i_cfg_rowWidth = 11'd640;
        sendPoint(2'd1, 1'b1, '0, 10'd10, 9'd3, 1'b1, 19'h0178A);
        drain();

        // Wrapping region near the top of the address space
        cfgWrite(2'd2, 19'h7FFF0, 20'h00080);
        sendPoint(2'd2, 1'b0, 19'h00020, '0, '0, 1'b1, 19'h00010);
        sendPoint(2'd2, 1'b0, 19'h00080, '0, '0, 1'b0, '0);
        sendPoint(2'd2, 1'b0, 19'h0007F, '0, '0, 1'b1, 19'h0006F);
        sendPoint(2'd2, 1'b1, '0, 10'd16, 9'd0, 1'b1, 19'h00000);
        drain();
        check("drop_after_wrap", 64'(bus.o_MemMU_CR_A_dropCount), 64'd1);

        // Last word of the default region, then one far beyond it
        bus.i_cfg_rowWidth = 11'd1024;
        sendPoint(2'd3, 1'b1, '0, 10'd1023, 9'd511, 1'b1, 19'h7FFFF);
        bus.i_cfg_rowWidth = 11'd2047;
        sendPoint(2'd3, 1'b1, '0, 10'd0, 9'd511, 1'b0, '0);
        drain();
        check("drop_past_region", 64'(bus.o_MemMU_CR_A_dropCount), 64'(expDrop));

        // size=0 drops everything on the channel
        cfgWrite(2'd0, 19'h00000, 20'h00000);
        sendPoint(2'd0, 1'b0, 19'h00000, '0, '0, 1'b0, '0);
        drain();
        check("drop_size0", 64'(bus.o_MemMU_CR_A_dropCount), 64'd3);

        // Back-to-back burst under a stalling consumer, one drop mid-burst
        readyMode = 1;
        for (int i = 0; i < 8; i++) begin
            sendPoint(2'd3, 1'b0, 19'(19'h100 + i), '0, '0, 1'b1, 19'(19'h100 + i));
            if (i == 4) sendPoint(2'd0, 1'b0, 19'h00001, '0, '0, 1'b0, '0);
        end
        drain();
        readyMode = 0;
        @(posedge clk);
        #2;
        check("drop_during_stall", 64'(bus.o_MemMU_CR_A_dropCount), 64'd4);

        // Region write lands on the same edge as the point is accepted
        bus.i_cfg_we   = 1'b1;
        bus.i_cfg_ch   = 2'd3;
        bus.i_cfg_base = 19'h00200;
        bus.i_cfg_size = 20'h01000;
        sendPoint(2'd3, 1'b0, 19'h00005, '0, '0, 1'b1, 19'h00205);
        bus.i_cfg_we = 1'b0;
        drain();

        // Reset with two points in flight
        readyMode = 2;
        @(posedge clk);
        #2;
        sendPoint(2'd1, 1'b0, 19'h00010, '0, '0, 1'b1, 19'h01010);
        sendPoint(2'd1, 1'b0, 19'h00011, '0, '0, 1'b1, 19'h01011);
        check("pre_rst_valid", 64'(bus.o_MemMU_CR_A_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.o_MemMU_CR_A_valid), 64'd0);
        check("mid_rst_siu_ready", 64'(bus.o_SIU_ready), 64'd0);
        q.delete();
        expDrop = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        readyMode = 0;
        repeat (3) begin
            @(posedge clk);
            #2;
            check("no_pulse_after_rst", 64'(bus.o_MemMU_CR_A_valid), 64'd0);
        end
        check("drop_after_rst", 64'(bus.o_MemMU_CR_A_dropCount), 64'd0);
        sendPoint(2'd1, 1'b0, 19'h7FFFF, '0, '0, 1'b1, 19'h7FFFF);
        sendPoint(2'd3, 1'b0, 19'h00005, '0, '0, 1'b1, 19'h00005);
        sendPoint(2'd0, 1'b0, 19'h00009, '0, '0, 1'b1, 19'h00009);
        drain();

        // Three-channel instance: out-of-range region write and point channel
        bus3.i_cfg_we = 1'b1;  bus3.i_cfg_ch = 2'd3;
        bus3.i_cfg_base = 19'h00055; bus3.i_cfg_size = 20'h00000;
        @(posedge clk);
        #1;
        bus3.i_cfg_ch = 2'd2;  bus3.i_cfg_base = 19'h00040; bus3.i_cfg_size = 20'h00100;
        @(posedge clk);
        #1;
        bus3.i_cfg_we = 1'b0;
        sendPoint3(2'd0, 19'h00007, 1'b1, 19'h00007);
        sendPoint3(2'd1, 19'h7FFFF, 1'b1, 19'h7FFFF);
        sendPoint3(2'd2, 19'h00009, 1'b1, 19'h00049);
        sendPoint3(2'd3, 19'h00001, 1'b0, '0);
        drain();
        check("drop3_bad_channel", 64'(bus3.o_MemMU_CR_A_dropCount), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
